// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: end-of-range mode encoding and
// an elaboration-time parameter legality check.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  function automatic bit counter_params_ok(input int unsigned     width,
                                           input longint unsigned modulus,
                                           input longint unsigned reset_value);
    return (width >= 1) && (width <= 32) &&
           (modulus >= 2) && (modulus <= (64'd1 << width)) &&
           (reset_value < modulus);
  endfunction

endpackage

// File: rtl/counter_mod_step.sv
// Combinational modulo step: next count value and wrap flag for one enabled
// count in the requested direction, honouring wrap or saturate at the ends.
module counter_mod_step
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic             i_up,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  always_comb begin
    o_next = i_cur;
    o_wrap = 1'b0;
    if (i_up) begin
      if (i_cur != MAXV) begin
        o_next = i_cur + WIDTH'(1);
      end else if (i_mode == MODE_WRAP) begin
        o_next = '0;
        o_wrap = 1'b1;
      end
    end else begin
      if (i_cur != '0) begin
        o_next = i_cur - WIDTH'(1);
      end else if (i_mode == MODE_WRAP) begin
        o_next = MAXV;
        o_wrap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, clear, wrap/saturate modes, a
// combinational terminal count for cascading and a registered wrap pulse.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH       = 4,
  parameter longint unsigned MODULUS     = 16,
  parameter longint unsigned RESET_VALUE = 0
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN,
  input  logic             UP,
  input  logic             MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             CLR,
  output logic [WIDTH-1:0] Out,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  generate
    if (!counter_params_ok(WIDTH, MODULUS, RESET_VALUE)) begin : g_bad_params
      $error("param_updown_counter: illegal WIDTH/MODULUS/RESET_VALUE");
    end
  endgenerate

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic [WIDTH-1:0] w_load_val;

  counter_mod_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .i_cur  (r_out),
    .i_up   (UP),
    .i_mode (MODE),
    .o_next (w_next),
    .o_wrap (w_wrap)
  );

  // Out-of-range load values clamp to the top of the count range.
  assign w_load_val = (LOAD_VAL > MAXV) ? MAXV : LOAD_VAL;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_out  <= RST_V;
      r_wrap <= 1'b0;
    end else if (CLR) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else if (LOAD) begin
      r_out  <= w_load_val;
      r_wrap <= 1'b0;
    end else if (EN) begin
      r_out  <= w_next;
      r_wrap <= w_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign Out  = r_out;
  assign WRAP = r_wrap;
  assign TC   = EN & ((UP & (r_out == MAXV)) | (~UP & (r_out == '0)));

endmodule
